// File: rtl/spi_master_pkg.sv
// Shared types and mode constants for the SPI transfer master.
// The master implements mode 0 only: sck idles low and miso is sampled on the rising edge.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCK_LO,
    SCK_HI,
    TRAIL,
    RESP
  } state_t;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter that times one sck half-period.
// phase_end is high in the last clock of the current phase.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  output logic             phase_end
);

  logic [DIV_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= half_period;
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/spi_xfer_master.sv
// SPI mode-0 master: takes one command over valid/ready, shifts it out MSB-first
// on mosi while capturing miso, and returns the captured bits over valid/ready.
module spi_xfer_master
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DIV_W-1:0]  req_div,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sck,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DATA_W - 1);

  state_t state_q, state_d;

  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_aligned;

  logic accept, sample, fall, next_bit, finish, rsp_done;
  logic busy, phase_end, div_load;
  logic [DIV_W-1:0] div_load_val;

  // Left-align the command so the first bit to send sits in the MSB.
  assign tx_aligned = req_data << (LAST_IDX - req_len);

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q == SCK_LO) || (state_q == SCK_HI) || (state_q == TRAIL);
  assign div_load     = accept || (busy && phase_end);
  assign div_load_val = accept ? req_div : div_q;

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clock       (clock),
    .resetn      (resetn),
    .load        (div_load),
    .half_period (div_load_val),
    .phase_end   (phase_end)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    sample   = 1'b0;
    fall     = 1'b0;
    next_bit = 1'b0;
    finish   = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = SCK_LO;
        end
      end
      SCK_LO: begin
        if (phase_end) begin
          sample  = (SPI_CPHA == 1'b0);
          state_d = SCK_HI;
        end
      end
      SCK_HI: begin
        if (phase_end) begin
          fall = 1'b1;
          if (bit_cnt_q != '0) begin
            next_bit = 1'b1;
            state_d  = SCK_LO;
          end else begin
            state_d  = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (phase_end) begin
          finish  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_q      <= '0;
      rx_q      <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      sck       <= SPI_CPOL;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        // tx_q holds the bits still to send after the one already on mosi.
        tx_q      <= tx_aligned << 1;
        mosi      <= tx_aligned[DATA_W-1];
        rx_q      <= '0;
        div_q     <= req_div;
        bit_cnt_q <= {1'b0, req_len} + CNT_W'(1);
        ss_n      <= 1'b0;
      end
      if (sample) begin
        sck       <= ~SPI_CPOL;
        rx_q      <= {rx_q[DATA_W-2:0], miso};
        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
      end
      if (fall) begin
        sck <= SPI_CPOL;
      end
      if (next_bit) begin
        tx_q <= tx_q << 1;
        mosi <= tx_q[DATA_W-1];
      end
      if (finish) begin
        ss_n      <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_data  <= rx_q;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
